// File: rtl/crane_pkg.sv
// Shared crane definitions: action codes and dispatcher state encoding.
// Used by the crane controller, the job dispatcher and their benches.
package crane_pkg;

  localparam logic [2:0] ACT_DN      = 3'b000;
  localparam logic [2:0] ACT_A1      = 3'b001;
  localparam logic [2:0] ACT_UP      = 3'b010;
  localparam logic [2:0] ACT_A2      = 3'b011;
  localparam logic [2:0] ACT_R1      = 3'b100;
  localparam logic [2:0] ACT_R2      = 3'b101;
  localparam logic [2:0] ACT_NOTHING = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_R2    = 3'd3,
    ST_WAIT_HOME  = 3'd4,
    ST_HALT       = 3'd5
  } disp_state_t;

  function automatic logic is_wait(disp_state_t s);
    return (s == ST_WAIT_START) ||
           (s == ST_WAIT_R2) ||
           (s == ST_WAIT_HOME);
  endfunction

endpackage

// File: rtl/crane_job_fifo.sv
// Circular job buffer: DEPTH entries of ANGLE_W bits.
// Overflowing pushes and underflowing pops are dropped.
module crane_job_fifo #(
  parameter int DEPTH   = 4,
  parameter int ANGLE_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [ANGLE_W-1:0]       push_data,
  input  logic                     pop,
  output logic [ANGLE_W-1:0]       pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [ANGLE_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic [AW:0]        cnt;
  logic               do_push;
  logic               do_pop;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign level    = cnt;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rptr];

  // Storage array; contents become irrelevant once pointers reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/crane_job_dispatcher.sv
// Queues crane lift jobs and dispatches one per full crane cycle.
// Optional per-job watchdog: define CRANE_DISP_TIMEOUT_EN.
module crane_job_dispatcher
  import crane_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int ANGLE_W        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic [ANGLE_W-1:0]     req_angle,
  output logic                   req_ready,
  input  logic [2:0]             crane_action,
  output logic                   crane_write_mode,
  output logic [ANGLE_W-1:0]     crane_angle,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   done_pulse,
  output logic                   timeout_err
);

  disp_state_t        state_q;
  disp_state_t        state_d;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [ANGLE_W-1:0] fifo_head;
  logic [ANGLE_W-1:0] angle_q;
  logic               done_q;
  logic               timeout_hit;

  assign req_ready = !fifo_full;
  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

  crane_job_fifo #(
    .DEPTH   (DEPTH),
    .ANGLE_W (ANGLE_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_valid),
    .push_data (req_angle),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

`ifdef CRANE_DISP_TIMEOUT_EN
  localparam int CW_MIN = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW     = (CW_MIN > 8) ? CW_MIN : 8;

  logic [CW-1:0] wd_cnt;
  logic          err_q;

  assign timeout_hit = is_wait(state_q) &&
                       (wd_cnt >= CW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = err_q;

  // Watchdog: restart on dispatch, count while waiting on crane.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == ST_ISSUE)    wd_cnt <= '0;
      else if (is_wait(state_q))  wd_cnt <= wd_cnt + 1'b1;
      if (timeout_hit)            err_q  <= 1'b1;
    end
  end
`else
  logic unused_tmo;

  assign unused_tmo  = (TIMEOUT_CYCLES != 0);
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State, held job angle and completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      angle_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fifo_pop) angle_q <= fifo_head;
      done_q  <= (state_q == ST_WAIT_HOME) &&
                 (state_d == ST_IDLE);
    end
  end

  // Next state follows the crane through one lift-and-return cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (crane_action != ACT_NOTHING) state_d = ST_WAIT_R2;
      end
      ST_WAIT_R2: begin
        if (crane_action == ACT_R2) state_d = ST_WAIT_HOME;
      end
      ST_WAIT_HOME: begin
        if (crane_action == ACT_NOTHING) state_d = ST_IDLE;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (timeout_hit) state_d = ST_HALT;
  end

  assign crane_write_mode = (state_q == ST_ISSUE);
  assign crane_angle      = angle_q;
  assign busy             = (state_q == ST_ISSUE) || is_wait(state_q);
  assign done_pulse       = done_q;

endmodule

// File: tb/tb_crane_job_dispatcher.sv
// Self-checking bench for crane_job_dispatcher.
// Table vectors, directed corner cases and a randomized crane model.
module tb_crane_job_dispatcher;
  import crane_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_angle;
  logic       req_ready;
  logic [2:0] crane_action;
  logic       crane_write_mode;
  logic [1:0] crane_angle;
  logic       busy;
  logic [2:0] level;
  logic       done_pulse;
  logic       timeout_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  crane_job_dispatcher #(
    .DEPTH          (DEPTH),
    .ANGLE_W        (2),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_angle        (req_angle),
    .req_ready        (req_ready),
    .crane_action     (crane_action),
    .crane_write_mode (crane_write_mode),
    .crane_angle      (crane_angle),
    .busy             (busy),
    .level            (level),
    .done_pulse       (done_pulse),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Crane walks its full cycle for a job already in ISSUE.
  task automatic finish_job(input logic [1:0] exp_ang);
    logic [2:0] seq [6];
    seq = '{ACT_DN, ACT_A1, ACT_UP, ACT_A2, ACT_R1, ACT_R2};
    chk("job_angle", crane_angle, exp_ang);
    for (int i = 0; i < 6; i++) begin
      crane_action = seq[i];
      step();
      chk("job_busy", busy, 1);
    end
    chk("job_no_reissue", crane_write_mode, 0);
    crane_action = ACT_NOTHING;
    step();
    chk("job_done", done_pulse, 1);
    chk("job_idle", busy, 0);
  endtask

  task automatic do_job(input logic [1:0] exp_ang);
    int n = 0;
    while (!crane_write_mode && n < 10) begin
      step();
      n++;
    end
    if (!crane_write_mode) begin
      chk("wm_timeout", 0, 1);
      return;
    end
    finish_job(exp_ang);
  endtask

  typedef struct {
    logic       v;
    logic [1:0] a;
    int         lvl;
    int         rdy;
    int         wm;
    int         bsy;
    int         ang;
  } vec_t;

  vec_t tv [7];

  logic [1:0] exp_q [$];
  logic [2:0] rseq [6];
  int acc, issued, phase, hold, idle_wait, wm_seen;
  bit active, done_due;

  initial begin
    tv[0] = '{1'b1, 2'd1, 1, 1, 0, 0, 0};
    tv[1] = '{1'b1, 2'd3, 1, 1, 1, 1, 1};
    tv[2] = '{1'b1, 2'd0, 2, 1, 0, 1, 1};
    tv[3] = '{1'b1, 2'd2, 3, 1, 0, 1, 1};
    tv[4] = '{1'b1, 2'd1, 4, 0, 0, 1, 1};
    tv[5] = '{1'b1, 2'd3, 4, 0, 0, 1, 1};
    tv[6] = '{1'b0, 2'd0, 4, 0, 0, 1, 1};

    reset        = 1'b0;
    req_valid    = 1'b0;
    req_angle    = '0;
    crane_action = ACT_NOTHING;
    step();
    chk("rst_level", level, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_wm", crane_write_mode, 0);
    chk("rst_angle", crane_angle, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_pulse, 0);
    chk("rst_err", timeout_err, 0);
    reset = 1'b1;
    step();

    // Fill the FIFO while the first job stalls in WAIT_START.
    for (int i = 0; i < 7; i++) begin
      req_valid = tv[i].v;
      req_angle = tv[i].a;
      step();
      chk($sformatf("tv%0d_level", i), level, tv[i].lvl);
      chk($sformatf("tv%0d_ready", i), req_ready, tv[i].rdy);
      chk($sformatf("tv%0d_wm", i), crane_write_mode, tv[i].wm);
      chk($sformatf("tv%0d_busy", i), busy, tv[i].bsy);
      chk($sformatf("tv%0d_angle", i), crane_angle, tv[i].ang);
    end

    finish_job(2'd1);
    chk("q_level4", level, 4);
    do_job(2'd3);
    do_job(2'd0);
    chk("q_level2", level, 2);

    // Push and pop on the same edge at level 2.
    req_valid = 1'b1;
    req_angle = 2'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("pp_level", level, 2);
    chk("pp_wm", crane_write_mode, 1);
    chk("pp_angle", crane_angle, 2);
    step();
    do_job(2'd2);
    do_job(2'd1);
    do_job(2'd3);
    step();
    chk("drain_level", level, 0);
    chk("drain_busy", busy, 0);
    chk("drain_angle_hold", crane_angle, 3);

    // Reset in the middle of a job discards everything.
    req_valid = 1'b1;
    req_angle = 2'd2;
    step();
    req_angle = 2'd1;
    step();
    req_valid = 1'b0;
    chk("mid_wm", crane_write_mode, 1);
    crane_action = ACT_DN;
    step();
    crane_action = ACT_A1;
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("mr_level", level, 0);
    chk("mr_ready", req_ready, 1);
    chk("mr_wm", crane_write_mode, 0);
    chk("mr_angle", crane_angle, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done_pulse, 0);
    chk("mr_err", timeout_err, 0);
    step();
    reset = 1'b1;
    crane_action = ACT_NOTHING;
    wm_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (crane_write_mode) wm_seen++;
    end
    chk("mr_no_dispatch", wm_seen, 0);
    chk("mr_still_idle", busy, 0);

    // Crane stalls at A1 with another job queued.
    req_valid = 1'b1;
    req_angle = 2'd1;
    step();
    req_angle = 2'd2;
    step();
    req_valid = 1'b0;
    chk("st_wm", crane_write_mode, 1);
    crane_action = ACT_A1;
`ifdef CRANE_DISP_TIMEOUT_EN
    for (int i = 0; i < 19; i++) step();
    chk("st_err_early", timeout_err, 0);
    for (int i = 0; i < 3; i++) step();
    chk("st_err", timeout_err, 1);
    chk("st_busy", busy, 0);
    wm_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (crane_write_mode) wm_seen++;
    end
    chk("st_halted", wm_seen, 0);
    chk("st_level", level, 1);
`else
    for (int i = 0; i < 300; i++) step();
    chk("st_err", timeout_err, 0);
    chk("st_busy", busy, 1);
    chk("st_level", level, 1);
`endif

    reset = 1'b0;
    crane_action = ACT_NOTHING;
    step();
    reset = 1'b1;
    step();

    // Randomized traffic against a job-count model.
    rseq = '{ACT_DN, ACT_A1, ACT_UP, ACT_A2, ACT_R1, ACT_R2};
    acc = 0;
    issued = 0;
    active = 0;
    done_due = 0;
    idle_wait = 0;
    phase = 0;
    hold = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (done_due) begin
        chk("rnd_done", done_pulse, 1);
        active = 0;
        done_due = 0;
      end else begin
        chk("rnd_no_done", done_pulse, 0);
      end
      if (crane_write_mode) begin
        chk("rnd_wm_while_active", active, 0);
        if (exp_q.size() == 0) chk("rnd_wm_empty", 1, 0);
        else chk("rnd_order", crane_angle, exp_q.pop_front());
        issued++;
        active = 1;
        phase = 0;
        hold = $urandom_range(1, 2);
        crane_action = rseq[0];
      end else if (active && phase < 6) begin
        hold--;
        if (hold == 0) begin
          phase++;
          if (phase == 6) begin
            crane_action = ACT_NOTHING;
            done_due = 1;
          end else begin
            crane_action = rseq[phase];
            hold = $urandom_range(1, 2);
          end
        end
      end
      chk("rnd_busy", busy, active);
      chk("rnd_level", level, acc - issued);
      chk("rnd_ready", req_ready, (acc - issued) < DEPTH);
      chk("rnd_err", timeout_err, 0);
      if (!active && (acc - issued) > 0) idle_wait++;
      else idle_wait = 0;
      chk("rnd_stall", idle_wait <= 2, 1);
      req_valid = ($urandom_range(0, 2) == 0);
      req_angle = 2'($urandom_range(0, 3));
      if (req_valid && req_ready) begin
        acc++;
        exp_q.push_back(req_angle);
      end
    end
    req_valid = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
